conv_tile_loader: RTL and testbench
===================================

// Module: conv_tile_loader
// PURPOSE
//  Upstream feeder for the single-PE 3x3 convolution stage. Accepts a byte stream
//  (valid/ready), assembles one 3x3 kernel and one 4x4 input tile in registers and
//  presents them in parallel to the PE. Starts the PE by releasing its reset, then
//  waits for done_single. Kernel can be retained across tiles to stream many tiles.
// PARAMETERS
//  DATA_W        8    element width (bits)
//  DONE_TIMEOUT  255  max RUN cycles waiting for done_single before abort
// PORTS
//  clk          in   1          system clock
//  rst          in   1          async active-high reset
//  in_data      in   DATA_W     stream byte
//  in_valid     in   1          in_data valid
//  in_sof       in   1          first beat of a frame
//  in_keep_ker  in   1          sampled with in_sof: 1 = frame has no kernel bytes
//  in_ready     out  1          loader accepts beat (beat = in_valid & in_ready)
//  kernel_flat  out  9*DATA_W   kernel_rc at [DATA_W*((r-1)*3+c-1) +: DATA_W]
//  mat_flat     out  16*DATA_W  mat_in_rc at [DATA_W*((r-1)*4+c-1) +: DATA_W]
//  pe_rst       out  1          drives PE rst; high holds PE idle
//  done_single  in   1          PE completion flag
//  busy         out  1          high in any state but IDLE
//  tile_done    out  1          1-cycle pulse: PE finished current tile
//  frame_err    out  1          1-cycle pulse: protocol violation
//  timeout_err  out  1          1-cycle pulse: done_single never arrived
// BEHAVIOUR
//  Reset: kernel_flat=0, mat_flat=0, pe_rst=1, in_ready=0, busy/tile_done/frame_err/
//   timeout_err=0, state=IDLE, counters=0. in_ready rises first cycle after reset.
//  Frame: [9 kernel bytes, row-major] (omitted if in_keep_ker) then 16 tile bytes row-major.
//  FSM IDLE -> LOAD_KER -> LOAD_MAT -> RUN -> IDLE. All outputs registered.
//  IDLE: in_ready=1. Beat with in_sof: byte stored as index 0 (kernel if keep=0 ->
//   LOAD_KER idx=1; else tile -> LOAD_MAT idx=1). Beat without in_sof: dropped, frame_err.
//  LOAD_KER: in_ready=1; beat writes kernel[idx]; after idx 8 -> LOAD_MAT idx=0.
//  LOAD_MAT: in_ready=1; beat writes mat[idx]; after idx 15 -> RUN; in_ready=0 and
//   pe_rst=0 on the next cycle (1-cycle latency from last beat).
//  In LOAD_*: beat with in_sof aborts frame, frame_err pulses, beat restarts a new frame
//   exactly as in IDLE. Gaps (in_valid=0) allowed anywhere; nothing advances without a beat.
//  RUN: in_ready=0, kernel_flat/mat_flat frozen. Cycle counter from 0; done_single honoured
//   only when pe_rst has been low >=1 cycle. done_single=1 -> tile_done pulse, pe_rst=1,
//   IDLE. Counter == DONE_TIMEOUT with no done -> timeout_err pulse, pe_rst=1, IDLE.
//   done_single and timeout in same cycle: done wins, no timeout_err.
//  Registers retain last values after RUN; keep=1 reuses last kernel (zeros after reset).
//  rst mid-frame/mid-RUN: immediate return to reset values, partial frame discarded.
//  No arithmetic; elements passed unmodified.
// STRUCTURE
//  Package conv_pkg: DATA_W, MAT_N=4, KER_N=3, MAT_ELEMS=16, KER_ELEMS=9, state enum
//   (IDLE, LOAD_KER, LOAD_MAT, RUN) -- shared with PE and downstream stages.
//  Single module; no sub-module. One 4-bit element index, one 8-bit RUN counter.
//  Top level unflattens kernel_flat/mat_flat onto PE's kernel_rc/mat_in_rc ports.
// TESTING (bench uses PE behavioural stub with programmable done delay)
//  1 Frame keep=0: kernel 1,0,1,1,1,0,0,1,1; tile 2,1,3,1,0,2,4,2,1,3,2,0,2,1,0,1 ->
//    kernel_flat=72'h010100000101010001, mat_flat=128'h01000102000203010204020001030102,
//    pe_rst falls 1 cycle after 25th beat; stub done after 12 cycles -> tile_done once.
//  2 Second frame keep=1, 16 bytes all 8'h05 -> kernel_flat unchanged, mat_flat all 05.
//  3 in_valid toggled randomly 50% during frame -> same results as test 1, beat count 25.
//  4 in_sof reasserted at beat 12 -> frame_err 1 pulse, new frame from that beat loads ok.
//  5 Stub never asserts done -> timeout_err after 255 RUN cycles, pe_rst=1, in_ready=1.
//  6 rst pulsed at beat 20 and mid-RUN -> all outputs at reset values, next frame clean.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the single-PE 3x3 convolution datapath.
// Holds element width, tile/kernel geometry and the loader state encoding so the
// loader, the PE and downstream stages agree on one set of constants.
package conv_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned MAT_N     = 4;
    localparam int unsigned KER_N     = 3;
    localparam int unsigned MAT_ELEMS = MAT_N * MAT_N;
    localparam int unsigned KER_ELEMS = KER_N * KER_N;

    // One index covers both kernel (0..8) and tile (0..15) positions.
    localparam int unsigned IDX_W = 4;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        StIdle,
        StLoadKer,
        StLoadMat,
        StRun
    } loader_state_e;

endpackage

// File: rtl/conv_tile_loader.sv
// conv_tile_loader
// Collects a byte stream into one 3x3 kernel and one 4x4 tile, presents both in
// parallel to the PE, releases the PE reset and waits for its completion flag.
// A frame is [9 kernel bytes] 16 tile bytes, row-major; the kernel bytes are left
// out when in_keep_ker is set with in_sof, in which case the stored kernel is reused.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_data/in_valid    stream byte and its qualifier; in_sof marks first beat
//   in_keep_ker         sampled with in_sof: frame carries no kernel bytes
//   in_ready            beat = in_valid & in_ready
//   kernel_flat         element i (row-major) at [DATA_W*i +: DATA_W]
//   mat_flat            element i (row-major) at [DATA_W*i +: DATA_W]
//   pe_rst              high holds the PE idle; low while the PE runs
//   done_single         PE completion flag
//   busy                high whenever not idle
//   tile_done           1-cycle pulse when the PE finished the tile
//   frame_err           1-cycle pulse on a protocol violation
//   timeout_err         1-cycle pulse when done_single never arrived
module conv_tile_loader
    import conv_pkg::*;
#(
    parameter int unsigned DATA_W       = conv_pkg::DATA_W,
    parameter int unsigned DONE_TIMEOUT = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_W-1:0]             in_data,
    input  logic                          in_valid,
    input  logic                          in_sof,
    input  logic                          in_keep_ker,
    output logic                          in_ready,
    output logic [KER_ELEMS*DATA_W-1:0]   kernel_flat,
    output logic [MAT_ELEMS*DATA_W-1:0]   mat_flat,
    output logic                          pe_rst,
    input  logic                          done_single,
    output logic                          busy,
    output logic                          tile_done,
    output logic                          frame_err,
    output logic                          timeout_err
);

    localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(DONE_TIMEOUT);
    localparam logic [IDX_W-1:0] KerLast    = IDX_W'(KER_ELEMS - 1);
    localparam logic [IDX_W-1:0] MatLast    = IDX_W'(MAT_ELEMS - 1);

    loader_state_e     state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] kernel_q [KER_ELEMS];
    logic [DATA_W-1:0] kernel_d [KER_ELEMS];
    logic [DATA_W-1:0] mat_q    [MAT_ELEMS];
    logic [DATA_W-1:0] mat_d    [MAT_ELEMS];
    logic              pe_rst_q, pe_rst_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;
    logic              tile_done_q, tile_done_d;
    logic              frame_err_q, frame_err_d;
    logic              timeout_err_q, timeout_err_d;
    logic              beat;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        kernel_d      = kernel_q;
        mat_d         = mat_q;
        pe_rst_d      = pe_rst_q;
        tile_done_d   = 1'b0;
        frame_err_d   = 1'b0;
        timeout_err_d = 1'b0;
        beat          = in_valid && in_ready_q;

        unique case (state_q)
            StIdle, StLoadKer, StLoadMat: begin
                if (beat) begin
                    if (in_sof) begin
                        // SOF always starts a new frame; mid-frame it also drops the old one.
                        frame_err_d = (state_q != StIdle);
                        idx_d       = IDX_W'(1);
                        if (in_keep_ker) begin
                            mat_d[0] = in_data;
                            state_d  = StLoadMat;
                        end else begin
                            kernel_d[0] = in_data;
                            state_d     = StLoadKer;
                        end
                    end else if (state_q == StIdle) begin
                        frame_err_d = 1'b1;
                    end else if (state_q == StLoadKer) begin
                        kernel_d[idx_q] = in_data;
                        if (idx_q == KerLast) begin
                            idx_d   = '0;
                            state_d = StLoadMat;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        mat_d[idx_q] = in_data;
                        if (idx_q == MatLast) begin
                            idx_d    = '0;
                            cnt_d    = '0;
                            pe_rst_d = 1'b0;
                            state_d  = StRun;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
            end
            StRun: begin
                // done is checked first so it wins over a coincident timeout.
                if (done_single && !pe_rst_q) begin
                    tile_done_d = 1'b1;
                    pe_rst_d    = 1'b1;
                    state_d     = StIdle;
                end else if (cnt_q == TimeoutCnt) begin
                    timeout_err_d = 1'b1;
                    pe_rst_d      = 1'b1;
                    state_d       = StIdle;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        in_ready_d = (state_d != StRun);
        busy_d     = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            idx_q         <= '0;
            cnt_q         <= '0;
            kernel_q      <= '{default: '0};
            mat_q         <= '{default: '0};
            pe_rst_q      <= 1'b1;
            in_ready_q    <= 1'b0;
            busy_q        <= 1'b0;
            tile_done_q   <= 1'b0;
            frame_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            kernel_q      <= kernel_d;
            mat_q         <= mat_d;
            pe_rst_q      <= pe_rst_d;
            in_ready_q    <= in_ready_d;
            busy_q        <= busy_d;
            tile_done_q   <= tile_done_d;
            frame_err_q   <= frame_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    for (genvar i = 0; i < KER_ELEMS; i++) begin : g_ker_flat
        assign kernel_flat[DATA_W*i +: DATA_W] = kernel_q[i];
    end

    for (genvar i = 0; i < MAT_ELEMS; i++) begin : g_mat_flat
        assign mat_flat[DATA_W*i +: DATA_W] = mat_q[i];
    end

    assign in_ready    = in_ready_q;
    assign pe_rst      = pe_rst_q;
    assign busy        = busy_q;
    assign tile_done   = tile_done_q;
    assign frame_err   = frame_err_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_conv_tile_loader.sv
// Bench for conv_tile_loader: directed frames, a behavioural PE stub with a
// programmable done delay, and a scoreboard of expected output events.
module tb_conv_tile_loader;

    localparam int EvRun  = 0;  // pe_rst fell: kernel/mat presented to PE
    localparam int EvDone = 1;
    localparam int EvErr  = 2;
    localparam int EvTo   = 3;

    typedef struct {
        int           kind;
        logic [71:0]  ker;
        logic [127:0] mat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_sof;
    logic         in_keep_ker;
    logic         in_ready;
    logic [71:0]  kernel_flat;
    logic [127:0] mat_flat;
    logic         pe_rst;
    logic         done_single;
    logic         busy;
    logic         tile_done;
    logic         frame_err;
    logic         timeout_err;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb_q[$];
    logic prev_pe_rst = 1'b1;
    int   beat_cnt = 0;

    logic [7:0] ker_b [9];
    logic [7:0] mat_b [16];

    // PE stub: counts cycles out of reset, raises done after stub_delay cycles.
    bit stub_en    = 1'b1;
    int stub_delay = 12;
    int stub_cnt;

    always #5 clk = ~clk;

    conv_tile_loader #(
        .DATA_W       (8),
        .DONE_TIMEOUT (255)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_sof      (in_sof),
        .in_keep_ker (in_keep_ker),
        .in_ready    (in_ready),
        .kernel_flat (kernel_flat),
        .mat_flat    (mat_flat),
        .pe_rst      (pe_rst),
        .done_single (done_single),
        .busy        (busy),
        .tile_done   (tile_done),
        .frame_err   (frame_err),
        .timeout_err (timeout_err)
    );

    always @(posedge clk or posedge pe_rst) begin
        if (pe_rst) stub_cnt <= 0;
        else        stub_cnt <= stub_cnt + 1;
    end
    assign done_single = stub_en && !pe_rst && (stub_cnt >= stub_delay - 1);

    always @(posedge clk) begin
        if (!rst && in_valid && in_ready) beat_cnt <= beat_cnt + 1;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_ev(input int kind, input logic [71:0] k, input logic [127:0] m);
        exp_t e;
        e.kind = kind;
        e.ker  = k;
        e.mat  = m;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop(input int kind);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_unexpected_event: got kind %0d expected none", kind);
        end else begin
            e = sb_q.pop_front();
            chk("sb_event_kind", 128'(kind), 128'(e.kind));
            if (kind == EvRun && e.kind == EvRun) begin
                chk("sb_kernel_flat", 128'(kernel_flat), 128'(e.ker));
                chk("sb_mat_flat", mat_flat, e.mat);
            end
        end
    endtask

    // Monitor: sample away from the active edge, pop one expectation per event.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_pe_rst && !pe_rst) sb_pop(EvRun);
            if (frame_err)              sb_pop(EvErr);
            if (tile_done)              sb_pop(EvDone);
            if (timeout_err)            sb_pop(EvTo);
        end
        prev_pe_rst <= pe_rst;
    end

    // Called and returns at 1 time unit after a rising edge.
    task automatic send_beat(input logic [7:0] d, input logic sof, input logic keep,
                             input bit gaps);
        int guard;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        in_data     = d;
        in_sof      = sof;
        in_keep_ker = keep;
        in_valid    = 1'b1;
        guard       = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL in_ready_wait: got 0 expected 1 within 50 cycles");
        end
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        in_sof      = 1'b0;
        in_keep_ker = 1'b0;
    endtask

    task automatic send_frame(input bit keep, input int nbeats, input bit gaps);
        int         total;
        logic [7:0] d;
        total = keep ? 16 : 25;
        for (int b = 0; b < nbeats; b++) begin
            if (!keep && b < 9) d = ker_b[b];
            else                d = mat_b[keep ? b : b - 9];
            if (b == total - 1) chk("pe_rst_high_before_last_beat", 128'(pe_rst), 128'(1));
            send_beat(d, (b == 0), keep && (b == 0), gaps);
            if (b == total - 1) begin
                chk("pe_rst_low_after_last_beat", 128'(pe_rst), 128'(0));
                chk("in_ready_low_in_run", 128'(in_ready), 128'(0));
                chk("busy_in_run", 128'(busy), 128'(1));
            end
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 600) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, 128'(busy), 128'(0));
    endtask

    task automatic check_reset_values(input string name);
        chk({name, "_kernel"}, 128'(kernel_flat), 128'(0));
        chk({name, "_mat"}, mat_flat, 128'(0));
        chk({name, "_pe_rst"}, 128'(pe_rst), 128'(1));
        chk({name, "_in_ready"}, 128'(in_ready), 128'(0));
        chk({name, "_flags"}, 128'({busy, tile_done, frame_err, timeout_err}), 128'(0));
    endtask

    initial begin
        int bc0;
        int n;
        rst         = 1'b1;
        in_data     = '0;
        in_valid    = 1'b0;
        in_sof      = 1'b0;
        in_keep_ker = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("in_ready_after_reset", 128'(in_ready), 128'(1));

        // 1: full frame with kernel.
        ker_b = '{8'd1, 8'd0, 8'd1, 8'd1, 8'd1, 8'd0, 8'd0, 8'd1, 8'd1};
        mat_b = '{8'd2, 8'd1, 8'd3, 8'd1, 8'd0, 8'd2, 8'd4, 8'd2,
                  8'd1, 8'd3, 8'd2, 8'd0, 8'd2, 8'd1, 8'd0, 8'd1};
        push_ev(EvRun, 72'h010100000101010001, 128'h01000102000203010204020001030102);
        push_ev(EvDone, '0, '0);
        send_frame(1'b0, 25, 1'b0);
        wait_idle("t1_idle");

        // 2: keep kernel, tile all 05.
        mat_b = '{default: 8'h05};
        push_ev(EvRun, 72'h010100000101010001, {16{8'h05}});
        push_ev(EvDone, '0, '0);
        send_frame(1'b1, 16, 1'b0);
        wait_idle("t2_idle");

        // 3: test-1 frame with random gaps.
        ker_b = '{8'd1, 8'd0, 8'd1, 8'd1, 8'd1, 8'd0, 8'd0, 8'd1, 8'd1};
        mat_b = '{8'd2, 8'd1, 8'd3, 8'd1, 8'd0, 8'd2, 8'd4, 8'd2,
                  8'd1, 8'd3, 8'd2, 8'd0, 8'd2, 8'd1, 8'd0, 8'd1};
        push_ev(EvRun, 72'h010100000101010001, 128'h01000102000203010204020001030102);
        push_ev(EvDone, '0, '0);
        bc0 = beat_cnt;
        send_frame(1'b0, 25, 1'b1);
        chk("t3_beat_count", 128'(beat_cnt - bc0), 128'(25));
        wait_idle("t3_idle");

        // 4: 12 beats then SOF restarts a new frame.
        ker_b = '{default: 8'hEE};
        mat_b = '{default: 8'hEE};
        push_ev(EvErr, '0, '0);
        push_ev(EvRun, 72'h010203040506070809, 128'h1f1e1d1c1b1a19181716151413121110);
        push_ev(EvDone, '0, '0);
        send_frame(1'b0, 12, 1'b0);
        ker_b = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        for (int i = 0; i < 16; i++) mat_b[i] = 8'(8'h10 + i);
        send_frame(1'b0, 25, 1'b0);
        wait_idle("t4_idle");

        // 5: PE never completes.
        stub_en = 1'b0;
        mat_b   = '{default: 8'h07};
        push_ev(EvRun, 72'h010203040506070809, {16{8'h07}});
        push_ev(EvTo, '0, '0);
        send_frame(1'b1, 16, 1'b0);
        n = 0;
        while (!timeout_err && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        // Counter values 0..255 each occupy one RUN cycle before the abort.
        chk("t5_timeout_latency", 128'(n), 128'(256));
        chk("t5_pe_rst_after_timeout", 128'(pe_rst), 128'(1));
        chk("t5_in_ready_after_timeout", 128'(in_ready), 128'(1));
        stub_en = 1'b1;

        // 6a: reset at beat 20.
        ker_b = '{default: 8'h33};
        mat_b = '{default: 8'h44};
        send_frame(1'b0, 20, 1'b0);
        rst = 1'b1;
        #1;
        check_reset_values("t6a_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 6b: reset mid-RUN.
        stub_delay = 100;
        ker_b = '{default: 8'h11};
        mat_b = '{default: 8'h22};
        push_ev(EvRun, {9{8'h11}}, {16{8'h22}});
        send_frame(1'b0, 25, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_reset_values("t6b_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 6c: clean frame after reset; kept kernel is now zero.
        stub_delay = 12;
        for (int i = 0; i < 16; i++) mat_b[i] = 8'(8'h40 + i);
        push_ev(EvRun, 72'h0, 128'h4f4e4d4c4b4a49484746454443424140);
        push_ev(EvDone, '0, '0);
        send_frame(1'b1, 16, 1'b0);
        wait_idle("t6c_idle");

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 128'(sb_q.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
